// File: rtl/pdb_sequencer.sv
// pdb_sequencer
// Post-FFT buffer controller for the pulse-ox pipeline. It captures one FFT
// frame as per-bin power (I^2 + Q^2) into an external single-port RAM, reads
// back the DC bin, scans for the strongest AC bin (index >= MIN_AC_BIN), then
// time-shares one external iterative sqrt unit (DC first, then the AC peak)
// and reports both magnitudes.
//
// Ports
//   clk_i, reset_i          clock, asynchronous active-high reset
//   fft_dv_i, fft_last_i    FFT sample valid / final bin of frame
//   fft_i_i, fft_q_i        signed I/Q sample
//   ram_addr_o, ram_we_o,   external RAM port; read data is valid one
//   ram_wdata_o, ram_rdata_i  cycle after the address is presented
//   sqrt_start_o, sqrt_operand_o, sqrt_done_i, sqrt_root_i  sqrt handshake
//   dc_component_o, ac_component_o, ac_bin_o  results, valid with new_comp_dv_o
//   pdb_done_o, pdb_clear_i status level and its clear
//   overrun_o, frame_err_o  sticky error flags (cleared by pdb_clear_i in DONE)
module pdb_sequencer #(
  parameter int N_BINS     = 1024,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 24,
  parameter int MIN_AC_BIN = 13
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     fft_dv_i,
  input  logic                     fft_last_i,
  input  logic signed [DATA_W-1:0] fft_i_i,
  input  logic signed [DATA_W-1:0] fft_q_i,
  output logic [ADDR_W-1:0]        ram_addr_o,
  output logic                     ram_we_o,
  output logic [2*DATA_W-1:0]      ram_wdata_o,
  input  logic [2*DATA_W-1:0]      ram_rdata_i,
  output logic                     sqrt_start_o,
  output logic [2*DATA_W-1:0]      sqrt_operand_o,
  input  logic                     sqrt_done_i,
  input  logic [DATA_W-1:0]        sqrt_root_i,
  output logic [DATA_W-1:0]        dc_component_o,
  output logic [DATA_W-1:0]        ac_component_o,
  output logic [ADDR_W-1:0]        ac_bin_o,
  output logic                     new_comp_dv_o,
  output logic                     pdb_done_o,
  input  logic                     pdb_clear_i,
  output logic                     overrun_o,
  output logic                     frame_err_o
);

  localparam logic [ADDR_W-1:0] N_BINS_C = ADDR_W'(N_BINS);
  localparam logic [ADDR_W-1:0] MIN_AC_C = ADDR_W'(MIN_AC_BIN);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_RD_DC, S_SCAN, S_SQ_DC, S_SQ_AC, S_REPORT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]   cnt_q;        // accepted samples, saturates at N_BINS
  logic                last_q;       // fft_last seen; current cycle is the final write
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [2*DATA_W-1:0] wr_data_q;
  logic                dc_rd_q;      // RAM data this cycle is bin 0
  logic [2*DATA_W-1:0] dc_pow_q;
  logic [ADDR_W-1:0]   scan_addr_q;
  logic                cmp_q;        // RAM data this cycle belongs to cmp_idx_q
  logic [ADDR_W-1:0]   cmp_idx_q;
  logic [2*DATA_W-1:0] max_pow_q;
  logic [ADDR_W-1:0]   max_bin_q;
  logic                sq_busy_q;    // a sqrt request is outstanding
  logic [DATA_W-1:0]   dc_root_q;
  logic [DATA_W-1:0]   dc_comp_q, ac_comp_q;
  logic [ADDR_W-1:0]   ac_bin_q;
  logic                pdb_done_q, overrun_q, frame_err_q;

  // Squares are formed at full 2*DATA_W width from sign-extended operands so
  // (-2^(DATA_W-1))^2 is exact; the sum of two such squares still fits.
  logic signed [2*DATA_W-1:0] i_ext, q_ext, sq_i, sq_q;
  logic [2*DATA_W-1:0]        power;
  assign i_ext = (2*DATA_W)'(fft_i_i);
  assign q_ext = (2*DATA_W)'(fft_q_i);
  assign sq_i  = i_ext * i_ext;
  assign sq_q  = q_ext * q_ext;
  assign power = $unsigned(sq_i) + $unsigned(sq_q);

  // The final-write cycle of CAPTURE no longer takes samples.
  logic              accept, clear_ok, sq_ack;
  logic [ADDR_W-1:0] wr_idx;
  assign accept   = fft_dv_i && ((state_q == S_IDLE) ||
                                 (state_q == S_CAPTURE && !last_q));
  assign clear_ok = (state_q == S_DONE) && pdb_clear_i;
  assign sq_ack   = sq_busy_q && sqrt_done_i;
  assign wr_idx   = (state_q == S_IDLE) ? '0 : cnt_q;

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (fft_dv_i) state_d = S_CAPTURE;
      S_CAPTURE: if (last_q) state_d = S_RD_DC;
      S_RD_DC:   state_d = S_SCAN;
      // Exits once every address is issued; the last compare happens in this cycle.
      S_SCAN:    if (scan_addr_q >= cnt_q) state_d = S_SQ_DC;
      S_SQ_DC:   if (sq_ack) state_d = S_SQ_AC;
      S_SQ_AC:   if (sq_ack) state_d = S_REPORT;
      S_REPORT:  state_d = S_DONE;
      S_DONE:    if (pdb_clear_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q       <= '0;
      last_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      dc_rd_q     <= 1'b0;
      dc_pow_q    <= '0;
      scan_addr_q <= '0;
      cmp_q       <= 1'b0;
      cmp_idx_q   <= '0;
      max_pow_q   <= '0;
      max_bin_q   <= '0;
      sq_busy_q   <= 1'b0;
      dc_root_q   <= '0;
      dc_comp_q   <= '0;
      ac_comp_q   <= '0;
      ac_bin_q    <= '0;
      pdb_done_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      dc_rd_q <= 1'b0;
      cmp_q   <= 1'b0;

      if (accept) begin
        last_q <= fft_last_i;
        if (wr_idx < N_BINS_C) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= wr_idx;
          wr_data_q <= power;
          cnt_q     <= wr_idx + ADDR_W'(1);
        end else begin
          cnt_q <= wr_idx;
        end
        if (state_q == S_IDLE) begin
          max_pow_q <= '0;
          max_bin_q <= '0;
        end
      end

      if (state_q == S_RD_DC) begin
        last_q      <= 1'b0;
        dc_rd_q     <= 1'b1;
        scan_addr_q <= MIN_AC_C;
        if (cnt_q <= MIN_AC_C) frame_err_q <= 1'b1;
      end

      if (dc_rd_q) dc_pow_q <= ram_rdata_i;

      if (state_q == S_SCAN && scan_addr_q < cnt_q) begin
        cmp_q       <= 1'b1;
        cmp_idx_q   <= scan_addr_q;
        scan_addr_q <= scan_addr_q + ADDR_W'(1);
      end

      // Strict greater-than keeps the lowest bin on ties.
      if (cmp_q && ram_rdata_i > max_pow_q) begin
        max_pow_q <= ram_rdata_i;
        max_bin_q <= cmp_idx_q;
      end

      if (sqrt_start_o)  sq_busy_q <= 1'b1;
      else if (sq_ack)   sq_busy_q <= 1'b0;

      if (state_q == S_SQ_DC && sq_ack) dc_root_q <= sqrt_root_i;

      // Results load as REPORT is entered so they are valid with new_comp_dv.
      if (state_q == S_SQ_AC && sq_ack) begin
        dc_comp_q  <= dc_root_q;
        ac_comp_q  <= sqrt_root_i;
        ac_bin_q   <= max_bin_q;
        pdb_done_q <= 1'b1;
      end

      if (fft_dv_i && !accept) overrun_q <= 1'b1;

      // Placed last so a clear wins over a same-cycle overrun.
      if (clear_ok) begin
        pdb_done_q  <= 1'b0;
        overrun_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end
    end
  end

  // Output logic
  always_comb begin
    ram_we_o       = wr_en_q;
    ram_wdata_o    = wr_en_q ? wr_data_q : '0;
    ram_addr_o     = '0;
    sqrt_start_o   = 1'b0;
    sqrt_operand_o = '0;
    new_comp_dv_o  = (state_q == S_REPORT);
    if (wr_en_q)                 ram_addr_o = wr_addr_q;
    else if (state_q == S_SCAN)  ram_addr_o = scan_addr_q;
    if (state_q == S_SQ_DC) begin
      sqrt_start_o   = !sq_busy_q;
      sqrt_operand_o = dc_pow_q;
    end else if (state_q == S_SQ_AC) begin
      sqrt_start_o   = !sq_busy_q;
      sqrt_operand_o = max_pow_q;
    end
  end

  assign dc_component_o = dc_comp_q;
  assign ac_component_o = ac_comp_q;
  assign ac_bin_o       = ac_bin_q;
  assign pdb_done_o     = pdb_done_q;
  assign overrun_o      = overrun_q;
  assign frame_err_o    = frame_err_q;

endmodule

// File: tb/tb_pdb_sequencer.sv
// Testbench for pdb_sequencer: external RAM and sqrt unit models, a reference
// model computing expected writes and results from the frame contents, and
// monitors that pop and compare whenever the DUT writes RAM or reports.
module tb_pdb_sequencer;
  localparam int N_BINS = 1024, ADDR_W = 11, DATA_W = 24, MIN_AC_BIN = 13;

  logic clk = 1'b0, reset = 1'b1;
  logic fft_dv = 1'b0, fft_last = 1'b0;
  logic signed [DATA_W-1:0] fft_i = '0, fft_q = '0;
  logic [ADDR_W-1:0] ram_addr;
  logic ram_we;
  logic [2*DATA_W-1:0] ram_wdata, ram_rdata = '0;
  logic sqrt_start, sqrt_done = 1'b0;
  logic [2*DATA_W-1:0] sqrt_operand;
  logic [DATA_W-1:0] sqrt_root = '0;
  logic [DATA_W-1:0] dc_component, ac_component;
  logic [ADDR_W-1:0] ac_bin;
  logic new_comp_dv, pdb_done, pdb_clear = 1'b0, overrun, frame_err;

  pdb_sequencer #(.N_BINS(N_BINS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MIN_AC_BIN(MIN_AC_BIN)) dut (
    .clk_i(clk), .reset_i(reset), .fft_dv_i(fft_dv), .fft_last_i(fft_last),
    .fft_i_i(fft_i), .fft_q_i(fft_q), .ram_addr_o(ram_addr), .ram_we_o(ram_we),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .sqrt_start_o(sqrt_start),
    .sqrt_operand_o(sqrt_operand), .sqrt_done_i(sqrt_done), .sqrt_root_i(sqrt_root),
    .dc_component_o(dc_component), .ac_component_o(ac_component), .ac_bin_o(ac_bin),
    .new_comp_dv_o(new_comp_dv), .pdb_done_o(pdb_done), .pdb_clear_i(pdb_clear),
    .overrun_o(overrun), .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint isqrt(input longint v);
    longint lo = 0, hi = 64'd16777215, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // External RAM: registered read, one cycle latency
  logic [2*DATA_W-1:0] mem [0:2047];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Scoreboard queues
  typedef struct { int addr; longint data; } wr_t;
  typedef struct { longint dc; longint ac; int bin; bit ferr; } res_t;
  wr_t  wr_q[$];
  res_t res_q[$];
  wr_t  w_mon;
  res_t r_mon;
  int   frame_no = 0;

  always @(negedge clk) begin
    if (ram_we) begin
      if (wr_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL ram_write: unexpected write addr=%0d data=%0d, expected no write", ram_addr, ram_wdata);
      end else begin
        w_mon = wr_q.pop_front();
        check("ram_addr", longint'(ram_addr), longint'(w_mon.addr));
        check("ram_wdata", longint'(ram_wdata), w_mon.data);
      end
    end
    if (new_comp_dv) begin
      if (res_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL new_comp_dv: unexpected pulse dc=%0d ac=%0d bin=%0d, expected none", dc_component, ac_component, ac_bin);
      end else begin
        r_mon = res_q.pop_front();
        check("dc_component", longint'(dc_component), r_mon.dc);
        check("ac_component", longint'(ac_component), r_mon.ac);
        check("ac_bin", longint'(ac_bin), longint'(r_mon.bin));
        check("frame_err_at_report", longint'(frame_err), longint'(r_mon.ferr));
        $display("[TB] report %0d: dc=%0d ac=%0d bin=%0d ferr=%0d", frame_no, dc_component, ac_component, ac_bin, frame_err);
      end
    end
  end

  // External sqrt unit: result sq_lat cycles after a start
  int  sq_lat = 13, sq_cnt = 0, start_cnt = 0;
  bit  stale = 1'b0;
  longint sq_op = 0;
  initial begin
    forever begin
      @(negedge clk);
      sqrt_done = 1'b0;
      if (reset) stale = 1'b1;
      if (sq_cnt > 0) begin
        sq_cnt--;
        if (sq_cnt == 0) begin
          sqrt_done = 1'b1;
          sqrt_root = DATA_W'(isqrt(sq_op));
          if (!stale) check("sqrt_operand_held", longint'(sqrt_operand), sq_op);
        end
      end
      if (sqrt_start) begin
        if (!stale) check("sqrt_start_while_busy", longint'(sq_cnt), 0);
        stale = 1'b0;
        sq_op = longint'(sqrt_operand);
        sq_cnt = sq_lat;
        start_cnt++;
      end
    end
  end

  // Frame stimulus and reference model
  int fi[$], fq[$];
  longint exp_dc, exp_ac;
  int exp_bin;
  bit exp_ferr;

  function automatic longint pw(input int k);
    return longint'(fi[k]) * longint'(fi[k]) + longint'(fq[k]) * longint'(fq[k]);
  endfunction

  function automatic int rand_s24();
    logic signed [DATA_W-1:0] t;
    t = DATA_W'($urandom);
    return int'(t);
  endfunction

  task automatic build_zero(input int n);
    fi.delete(); fq.delete();
    for (int k = 0; k < n; k++) begin fi.push_back(0); fq.push_back(0); end
  endtask

  task automatic build_rand(input int n);
    int v;
    fi.delete(); fq.delete();
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 3))
        0: v = 0;
        1: v = 100;
        2: v = -100;
        default: v = rand_s24();
      endcase
      fi.push_back(v);
      fq.push_back(($urandom_range(0, 1) == 1) ? rand_s24() : 0);
    end
  endtask

  // Only the first N_BINS samples are stored; the AC peak is the first bin
  // at or above MIN_AC_BIN with the largest nonzero power.
  task automatic model_frame(input bit report);
    int stored;
    longint p, maxp;
    int mb;
    stored = (fi.size() > N_BINS) ? N_BINS : fi.size();
    maxp = 0; mb = 0;
    for (int k = 0; k < stored; k++) begin
      p = pw(k);
      wr_q.push_back('{k, p});
      if (k >= MIN_AC_BIN && p > maxp) begin maxp = p; mb = k; end
    end
    exp_dc = isqrt(pw(0));
    exp_ac = isqrt(maxp);
    exp_bin = mb;
    exp_ferr = (stored <= MIN_AC_BIN);
    if (report) res_q.push_back('{exp_dc, exp_ac, mb, exp_ferr});
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_samples(input bit gaps);
    for (int k = 0; k < fi.size(); k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      fft_dv = 1'b1;
      fft_i = DATA_W'(fi[k]);
      fft_q = DATA_W'(fq[k]);
      fft_last = (k == fi.size() - 1);
      tick();
      fft_dv = 1'b0;
      fft_last = 1'b0;
    end
  endtask

  task automatic drop_pulse();
    fft_dv = 1'b1;
    fft_i = DATA_W'($urandom);
    fft_q = DATA_W'($urandom);
    fft_last = 1'($urandom_range(0, 1));
    tick();
    fft_dv = 1'b0;
    fft_last = 1'b0;
  endtask

  task automatic run_frame(input bit drops, input bit gaps, input bit clr_dv);
    int base, c;
    frame_no++;
    base = start_cnt;
    model_frame(1'b1);
    send_samples(gaps);
    if (drops) begin
      repeat (6) tick();
      drop_pulse();
      c = 0;
      while (start_cnt < base + 2 && c < 5000) begin tick(); c++; end
      repeat (2) tick();
      drop_pulse();
    end
    c = 0;
    while (!pdb_done && c < 5000) begin tick(); c++; end
    check("pdb_done_set", longint'(pdb_done), 1);
    repeat (2) tick();
    check("report_popped", longint'(res_q.size()), 0);
    check("writes_all_seen", longint'(wr_q.size()), 0);
    check("pdb_done_held", longint'(pdb_done), 1);
    check("overrun", longint'(overrun), longint'(drops));
    check("frame_err", longint'(frame_err), longint'(exp_ferr));
    pdb_clear = 1'b1;
    fft_dv = clr_dv;
    tick();
    pdb_clear = 1'b0;
    fft_dv = 1'b0;
    check("pdb_done_cleared", longint'(pdb_done), 0);
    check("overrun_cleared", longint'(overrun), 0);
    check("frame_err_cleared", longint'(frame_err), 0);
    check("dc_kept_after_clear", longint'(dc_component), exp_dc);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dc"}, longint'(dc_component), 0);
    check({tag, "_ac"}, longint'(ac_component), 0);
    check({tag, "_ac_bin"}, longint'(ac_bin), 0);
    check({tag, "_new_comp_dv"}, longint'(new_comp_dv), 0);
    check({tag, "_pdb_done"}, longint'(pdb_done), 0);
    check({tag, "_overrun"}, longint'(overrun), 0);
    check({tag, "_frame_err"}, longint'(frame_err), 0);
    check({tag, "_ram_we"}, longint'(ram_we), 0);
    check({tag, "_sqrt_start"}, longint'(sqrt_start), 0);
    check({tag, "_sqrt_operand"}, longint'(sqrt_operand), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // 64-bin frame: DC 1000, peak at bin 20 (300,400)
    build_zero(64);
    fi[0] = 1000; fi[20] = 300; fq[20] = 400;
    run_frame(1'b0, 1'b0, 1'b0);
    check("t1_ram_bin0", longint'(mem[0]), 1000000);
    check("t1_dc", longint'(dc_component), 1000);
    check("t1_ac", longint'(ac_component), 500);
    check("t1_ac_bin", longint'(ac_bin), 20);

    // Tie at full-scale power 2^47: lowest bin wins
    build_zero(64);
    fi[15] = -8388608; fq[15] = -8388608;
    fi[40] = -8388608; fq[40] = -8388608;
    run_frame(1'b0, 1'b0, 1'b0);
    check("tie_ac", longint'(ac_component), 11863283);
    check("tie_ac_bin", longint'(ac_bin), 15);
    check("tie_ram_bin15", longint'(mem[15]), 64'd140737488355328);

    // Short frame: no AC-eligible bin
    build_rand(10);
    run_frame(1'b0, 1'b0, 1'b0);
    check("short_ac", longint'(ac_component), 0);
    check("short_ac_bin", longint'(ac_bin), 0);

    // Dropped samples during SCAN and SQ_AC
    build_zero(64);
    fi[0] = 1000; fi[20] = 300; fq[20] = 400;
    run_frame(1'b1, 1'b0, 1'b0);
    check("ovr_ac", longint'(ac_component), 500);
    check("ovr_ram_bin20", longint'(mem[20]), 250000);

    // Reset 5 cycles into the DC sqrt request; late sqrt_done must be ignored
    frame_no++;
    build_rand(64);
    model_frame(1'b0);
    base = start_cnt;
    send_samples(1'b0);
    c = 0;
    while (start_cnt == base && c < 2000) begin tick(); c++; end
    check("abort_dc_start_seen", longint'(start_cnt - base), 1);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check_all_zero("abort_in_reset");
    tick();
    reset = 1'b0;
    repeat (30) tick();
    check_all_zero("abort_after");
    check("abort_writes_seen", longint'(wr_q.size()), 0);

    // Next frame after the abort processes normally
    build_rand(40);
    run_frame(1'b0, 1'b1, 1'b0);

    // Oversized frame: only N_BINS stored and scanned
    build_rand(1100);
    run_frame(1'b0, 1'b0, 1'b0);

    // Randomized frames, some with clear and fft_dv together in DONE
    for (int r = 0; r < 8; r++) begin
      sq_lat = $urandom_range(1, 20);
      build_rand($urandom_range(1, 200));
      run_frame(1'($urandom_range(0, 1)) && (fi.size() > 30), 1'b1, 1'($urandom_range(0, 1)));
    end

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
